// File: rtl/baccarat_pkg.sv
// Shared types, seven-segment patterns and card helpers for the baccarat dealer.
package baccarat_pkg;

  typedef enum logic [2:0] {
    ST_P1, ST_D1, ST_P2, ST_D2, ST_THIRD, ST_BANK, ST_DONE
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_10    = 7'b1000000;
  localparam logic [6:0] SEG_J     = 7'b1100001;
  localparam logic [6:0] SEG_Q     = 7'b0011000;
  localparam logic [6:0] SEG_K     = 7'b0001001;

  localparam logic [3:0] CARD_MAX = 4'd13;

  // Face cards, tens and empty slots all count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
  endfunction

  // Banker third-card tableau: dealer score ds, player third-card value t.
  function automatic logic banker_draws(input logic [3:0] ds, input logic [3:0] t);
    case (ds)
      4'd0, 4'd1, 4'd2: return 1'b1;
      4'd3:             return t != 4'd8;
      4'd4:             return t >= 4'd2 && t <= 4'd7;
      4'd5:             return t >= 4'd4 && t <= 4'd7;
      4'd6:             return t >= 4'd6 && t <= 4'd7;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/baccarat_datapath.sv
// Free-running card source, the six hand registers and the mod-10 scores.
module baccarat_datapath
  import baccarat_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_p1,
  input  logic       ld_p2,
  input  logic       ld_p3,
  input  logic       ld_d1,
  input  logic       ld_d2,
  input  logic       ld_d3,
  output logic [3:0] new_card,
  output logic [3:0] PReg1_out,
  output logic [3:0] PReg2_out,
  output logic [3:0] PReg3_out,
  output logic [3:0] DReg1_out,
  output logic [3:0] DReg2_out,
  output logic [3:0] DReg3_out,
  output logic [3:0] pscore,
  output logic [3:0] dscore
);

  logic [3:0] card_q;
  logic [4:0] psum;
  logic [4:0] dsum;

  // NOTE: sequential state uses <= so every register samples pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) card_q <= 4'd1;
    else        card_q <= (card_q == CARD_MAX) ? 4'd1 : card_q + 4'd1;
  end

  assign new_card = card_q;

  // NOTE: the hand registers are reset so an empty slot reads 0 (blank, value 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PReg1_out <= '0;
      PReg2_out <= '0;
      PReg3_out <= '0;
      DReg1_out <= '0;
      DReg2_out <= '0;
      DReg3_out <= '0;
    end else begin
      if (ld_p1) PReg1_out <= new_card;
      if (ld_p2) PReg2_out <= new_card;
      if (ld_p3) PReg3_out <= new_card;
      if (ld_d1) DReg1_out <= new_card;
      if (ld_d2) DReg2_out <= new_card;
      if (ld_d3) DReg3_out <= new_card;
    end
  end

  assign psum   = 5'(card_value(PReg1_out)) + 5'(card_value(PReg2_out)) + 5'(card_value(PReg3_out));
  assign dsum   = 5'(card_value(DReg1_out)) + 5'(card_value(DReg2_out)) + 5'(card_value(DReg3_out));
  assign pscore = 4'(psum % 5'd10);
  assign dscore = 4'(dsum % 5'd10);

endmodule

// File: rtl/card7seg.sv
// Card rank (1..13) to active-low seven-segment pattern; 0/14/15 are blank.
module card7seg
  import baccarat_pkg::*;
(
  input  logic [3:0] card,
  output logic [6:0] seg
);

  always_comb begin
    case (card)
      4'd1:    seg = SEG_A;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      4'd10:   seg = SEG_10;
      4'd11:   seg = SEG_J;
      4'd12:   seg = SEG_Q;
      4'd13:   seg = SEG_K;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/baccarat_game.sv
// Punto Banco dealer top: step detect, dealing FSM, displays and result LEDs.
// Define KEY_SYNC_EN to pass KEY[0] through a 2-flop synchronizer first.
module baccarat_game
  import baccarat_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  logic clk, rst_n;
  assign clk   = CLOCK_50;
  assign rst_n = KEY[3];

  logic unused_keys;
  assign unused_keys = ^KEY[2:1];

  logic key0_s, key0_q, step;

`ifdef KEY_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], KEY[0]};
  end
  assign key0_s = sync_q[1];
`else
  assign key0_s = KEY[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key0_q <= 1'b1;
    else        key0_q <= key0_s;
  end

  // Button release (0->1) is the deal event.
  assign step = key0_s & ~key0_q;

  logic       ld_p1, ld_p2, ld_p3, ld_d1, ld_d2, ld_d3;
  logic [3:0] new_card, pscore, dscore;
  logic [3:0] p1, p2, p3, d1, d2, d3;

  baccarat_datapath dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_p1     (ld_p1),
    .ld_p2     (ld_p2),
    .ld_p3     (ld_p3),
    .ld_d1     (ld_d1),
    .ld_d2     (ld_d2),
    .ld_d3     (ld_d3),
    .new_card  (new_card),
    .PReg1_out (p1),
    .PReg2_out (p2),
    .PReg3_out (p3),
    .DReg1_out (d1),
    .DReg2_out (d2),
    .DReg3_out (d3),
    .pscore    (pscore),
    .dscore    (dscore)
  );

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_P1;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d = state_q;
    ld_p1 = 1'b0; ld_p2 = 1'b0; ld_p3 = 1'b0;
    ld_d1 = 1'b0; ld_d2 = 1'b0; ld_d3 = 1'b0;
    if (step) begin
      case (state_q)
        ST_P1: begin ld_p1 = 1'b1; state_d = ST_D1; end
        ST_D1: begin ld_d1 = 1'b1; state_d = ST_P2; end
        ST_P2: begin ld_p2 = 1'b1; state_d = ST_D2; end
        ST_D2: begin ld_d2 = 1'b1; state_d = ST_THIRD; end
        ST_THIRD: begin
          if (pscore >= 4'd8 || dscore >= 4'd8) begin
            state_d = ST_DONE;
          end else if (pscore <= 4'd5) begin
            ld_p3   = 1'b1;
            state_d = ST_BANK;
          end else begin
            ld_d3   = (dscore <= 4'd5);
            state_d = ST_DONE;
          end
        end
        ST_BANK: begin
          ld_d3   = banker_draws(dscore, card_value(p3));
          state_d = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  logic [1:0] winner;
  always_comb begin
    winner = 2'b00;
    if (state_q == ST_DONE) begin
      if      (pscore > dscore) winner = 2'b01;
      else if (dscore > pscore) winner = 2'b10;
      else                      winner = 2'b11;
    end
  end

  assign LEDR = {winner, dscore, pscore};

  card7seg u_hex0 (.card(p1), .seg(HEX0));
  card7seg u_hex1 (.card(p2), .seg(HEX1));
  card7seg u_hex2 (.card(p3), .seg(HEX2));
  card7seg u_hex3 (.card(d1), .seg(HEX3));
  card7seg u_hex4 (.card(d2), .seg(HEX4));
  card7seg u_hex5 (.card(d3), .seg(HEX5));

endmodule

// File: tb/tb_baccarat_game.sv
// Self-checking bench for baccarat_game: directed hands, random hands against a
// tableau model, counter wrap, reset and display decode.
module tb_baccarat_game;

  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  baccarat_game dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .LEDR     (LEDR),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;
  logic [6:0] seg_tbl [16];
  logic [3:0] card_r;
  logic [3:0] reg_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int val(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  // Plays one hand by the Punto Banco rules; h = {P1,P2,P3,D1,D2,D3}, 0 = not dealt.
  task automatic model(input int c[6], output int h[6], output int ps, output int ds);
    int t;
    bit draw;
    h = '{c[0], c[2], 0, c[1], c[3], 0};
    ps = (val(h[0]) + val(h[1])) % 10;
    ds = (val(h[3]) + val(h[4])) % 10;
    if (ps >= 8 || ds >= 8) begin
      // natural: both stand
    end else if (ps <= 5) begin
      h[2] = c[4];
      t = val(c[4]);
      ps = (ps + t) % 10;
      case (ds)
        0, 1, 2: draw = 1;
        3:       draw = (t != 8);
        4:       draw = (t >= 2 && t <= 7);
        5:       draw = (t >= 4 && t <= 7);
        6:       draw = (t >= 6 && t <= 7);
        default: draw = 0;
      endcase
      if (draw) begin
        h[5] = c[5];
        ds = (ds + val(c[5])) % 10;
      end
    end else if (ds <= 5) begin
      h[5] = c[4];
      ds = (ds + val(c[4])) % 10;
    end
  endtask

  task automatic reset_dut();
    @(negedge CLOCK_50);
    KEY = 4'b0111;
    @(negedge CLOCK_50);
    KEY = 4'b1111;
    @(negedge CLOCK_50);
  endtask

  task automatic press(input int c);
    card_r = 4'(c);
    force dut.dp.new_card = card_r;
    @(negedge CLOCK_50);
    KEY[0] = 1'b0;
    @(negedge CLOCK_50);
    KEY[0] = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    release dut.dp.new_card;
  endtask

  task automatic play_and_check(input string name, input int c[6]);
    int h[6];
    int ps, ds;
    logic [1:0] win;
    reset_dut();
    for (int i = 0; i < 6; i++) press(c[i]);
    model(c, h, ps, ds);
    win = (ps > ds) ? 2'b01 : (ds > ps) ? 2'b10 : 2'b11;
    check({name, ".hex0"}, 32'(HEX0), 32'(seg_tbl[h[0]]));
    check({name, ".hex1"}, 32'(HEX1), 32'(seg_tbl[h[1]]));
    check({name, ".hex2"}, 32'(HEX2), 32'(seg_tbl[h[2]]));
    check({name, ".hex3"}, 32'(HEX3), 32'(seg_tbl[h[3]]));
    check({name, ".hex4"}, 32'(HEX4), 32'(seg_tbl[h[4]]));
    check({name, ".hex5"}, 32'(HEX5), 32'(seg_tbl[h[5]]));
    check({name, ".ledr"}, 32'(LEDR), 32'({win, 4'(ds), 4'(ps)}));
  endtask

  initial begin
    int exp_card;
    int c[6];
    seg_tbl = '{7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
                7'b0011000, 7'b0001001, 7'b1111111, 7'b1111111};

    // Reset state and card counter wrap.
    KEY = 4'b0111;
    repeat (3) @(negedge CLOCK_50);
    check("rst.hex", 32'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), {32{1'b1}} & 32'h3FFFFFF | 32'(42'h3FFFFFFFFFF));
    check("rst.ledr", 32'(LEDR), 32'd0);
    check("rst.card", 32'(dut.dp.new_card), 32'd1);
    KEY = 4'b1111;
    exp_card = 1;
    for (int i = 0; i < 14; i++) begin
      check("ctr", 32'(dut.dp.new_card), 32'(exp_card));
      @(negedge CLOCK_50);
      exp_card = (exp_card == 13) ? 1 : exp_card + 1;
    end

    // Directed hands with hand-derived expectations.
    play_and_check("t2", '{1, 3, 5, 7, 9, 1});
    check("t2.hex0_A", 32'(HEX0), 32'(7'b0001000));
    check("t2.hex5_9", 32'(HEX5), 32'(7'b0010000));
    check("t2.ledr", 32'(LEDR), 32'({2'b10, 4'd9, 4'd6}));
    play_and_check("t3", '{4, 2, 5, 3, 11, 11});
    check("t3.hex2", 32'(HEX2), 32'(7'b1111111));
    check("t3.ledr", 32'(LEDR), 32'({2'b01, 4'd5, 4'd9}));
    play_and_check("t4", '{2, 3, 2, 13, 8, 6});
    check("t4.hex5", 32'(HEX5), 32'(7'b1111111));
    check("t4.ledr", 32'(LEDR), 32'({2'b10, 4'd3, 4'd2}));
    play_and_check("t5", '{3, 4, 4, 3, 1, 1});
    check("t5.ledr", 32'(LEDR), 32'({2'b11, 4'd7, 4'd7}));

    // Mid-game reset is asynchronous.
    reset_dut();
    press(6); press(7);
    @(negedge CLOCK_50);
    #2 KEY[3] = 1'b0;
    #1;
    check("midrst.hex", 32'({HEX3, HEX0}), 32'({7'h7F, 7'h7F}));
    check("midrst.ledr", 32'(LEDR), 32'd0);
    @(negedge CLOCK_50);
    KEY[3] = 1'b1;

    // Random hands against the model.
    for (int g = 0; g < 40; g++) begin
      for (int i = 0; i < 6; i++) c[i] = int'($urandom_range(1, 13));
      play_and_check($sformatf("rnd%0d", g), c);
    end

    // Display decode of every register value.
    reset_dut();
    for (int v = 0; v < 16; v++) begin
      reg_v = 4'(v);
      force dut.dp.PReg1_out = reg_v;
      force dut.dp.PReg2_out = reg_v;
      force dut.dp.PReg3_out = reg_v;
      force dut.dp.DReg1_out = reg_v;
      force dut.dp.DReg2_out = reg_v;
      force dut.dp.DReg3_out = reg_v;
      #1;
      check($sformatf("dec%0d.p", v), 32'({HEX2, HEX1, HEX0}), 32'({3{seg_tbl[v]}}));
      check($sformatf("dec%0d.d", v), 32'({HEX5, HEX4, HEX3}), 32'({3{seg_tbl[v]}}));
    end
    release dut.dp.PReg1_out;
    release dut.dp.PReg2_out;
    release dut.dp.PReg3_out;
    release dut.dp.DReg1_out;
    release dut.dp.DReg2_out;
    release dut.dp.DReg3_out;
    reset_dut();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
